// File: rtl/fc_ctrl_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
package fc_ctrl_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Payload carried alongside the MAC pipeline; idx is sized for the default count width
  typedef struct packed {
    logic                 last;
    logic [DEF_CNT_W-1:0] idx;
  } dl_payload_t;

endpackage

// File: rtl/fc_delay_line.sv
// Fixed-depth shift register that advances every cycle; used to track MAC pipeline latency.
module fc_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Walks N_IN x N_OUT MAC operations for one layer, emitting addresses and accumulator strobes,
// and aligns per-neuron result-valid and completion to the MAC pipeline latency.
module fc_layer_sequencer
  import fc_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              iStart,
  input  logic [CNT_W-1:0]  iNumIn,
  input  logic [CNT_W-1:0]  iNumOut,
  input  logic              iStall,
  output logic              oBusy,
  output logic              oMacEn,
  output logic [CNT_W-1:0]  oInAddr,
  output logic [ADDR_W-1:0] oWtAddr,
  output logic              oAccClr,
  output logic              oAccLast,
  output logic              oOutValid,
  output logic [CNT_W-1:0]  oOutIdx,
  output logic              oDone
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t state, state_next;

  logic [CNT_W-1:0]   num_in, num_out;
  logic [CNT_W-1:0]   i_cnt, j_cnt;
  logic [ADDR_W-1:0]  base;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   acc_idx;

  logic start_run, start_empty, issue, last_i, last_j, drain_done;

  logic              mac_en_d, clr_d, last_d, busy_d, done_d;
  logic [CNT_W-1:0]  in_addr_d;
  logic [ADDR_W-1:0] wt_addr_d;

  dl_payload_t dl_in, dl_out;

  assign start_run   = (state == IDLE) && iStart && (iNumIn != '0) && (iNumOut != '0);
  assign start_empty = (state == IDLE) && iStart && ((iNumIn == '0) || (iNumOut == '0));
  assign issue       = (state == RUN) && !iStall;
  assign last_i      = (i_cnt == num_in - CNT_W'(1));
  assign last_j      = (j_cnt == num_out - CNT_W'(1));
  assign drain_done  = (drain_cnt == DRAIN_W'(PIPE_LAT - 1));

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_run)        state_next = RUN;
        else if (start_empty) state_next = DONE;
      end
      RUN:     if (issue && last_i && last_j) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // While stalled in RUN the address outputs present the pending (not yet issued) MAC
  always_comb begin
    mac_en_d  = issue;
    clr_d     = issue && (i_cnt == '0);
    last_d    = issue && last_i;
    busy_d    = (state != IDLE);
    done_d    = (state == DONE);
    in_addr_d = oInAddr;
    wt_addr_d = oWtAddr;
    if (state == RUN) begin
      in_addr_d = i_cnt;
      wt_addr_d = base + ADDR_W'(i_cnt);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      num_in    <= '0;
      num_out   <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      base      <= '0;
      drain_cnt <= '0;
      acc_idx   <= '0;
      oMacEn    <= 1'b0;
      oAccClr   <= 1'b0;
      oAccLast  <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oInAddr   <= '0;
      oWtAddr   <= '0;
    end else begin
      oMacEn   <= mac_en_d;
      oAccClr  <= clr_d;
      oAccLast <= last_d;
      oBusy    <= busy_d;
      oDone    <= done_d;
      oInAddr  <= in_addr_d;
      oWtAddr  <= wt_addr_d;

      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                drain_cnt <= '0;

      if (start_run) begin
        num_in  <= iNumIn;
        num_out <= iNumOut;
        i_cnt   <= '0;
        j_cnt   <= '0;
        base    <= '0;
      end else if (issue) begin
        acc_idx <= j_cnt;
        // Weight base steps by N_IN per neuron so no multiplier is needed
        if (last_i) begin
          i_cnt <= '0;
          j_cnt <= j_cnt + CNT_W'(1);
          base  <= base + ADDR_W'(num_in);
        end else begin
          i_cnt <= i_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign dl_in = '{last: oAccLast, idx: DEF_CNT_W'(acc_idx)};

  fc_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH ($bits(dl_payload_t))
  ) u_delay (
    .clock (aclk),
    .reset (areset),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign oOutValid = dl_out.last;
  assign oOutIdx   = CNT_W'(dl_out.idx);

endmodule
